// File: rtl/pm_sched_pkg.sv
// Shared types and defaults for the pattern-merge scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pm_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_DATA_W   = 15;
    localparam int DEF_RES_W    = 13;
    localparam int DEF_PIPE_LAT = 2;
    localparam int DEF_CNT_W    = 16;

    // Index width that never collapses to zero bits for tiny requester counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pm_rr_arbiter.sv
// Round-robin pick: first valid requester at or after rr_ptr, wrapping upward.
// Latency: combinational.
// Backpressure: none; the caller decides whether a grant is used.
module pm_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    int j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        j         = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(rr_ptr) + i) % N_REQ;
            if (!any_grant && req_valid[j]) begin
                any_grant = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/pattern_merge_sched.sv
// Shares one combinational merge datapath among N_REQ requesters, round-robin.
// Latency: rsp_valid rises PIPE_LAT+1 cycles after the grant cycle.
// Backpressure: holds the response while rsp_ready is low; no grants until it drains.
module pattern_merge_sched
    import pm_sched_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RES_W    = DEF_RES_W,
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                         blif_clk_net,
    input  logic                         blif_reset_net,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*DATA_W-1:0]      req_data,
    output logic [DATA_W-1:0]            dp_in,
    input  logic [RES_W-1:0]             dp_out,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [clog2_min1(N_REQ)-1:0] rsp_id,
    output logic [RES_W-1:0]             rsp_data,
    input  logic                         abort,
    output logic                         busy,
    output logic [CNT_W-1:0]             ops_done
);

    localparam int IDX_W = clog2_min1(N_REQ);
    localparam int LAT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [LAT_W-1:0]  cnt;
    logic [N_REQ-1:0]  grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              any_grant;
    logic              load_req;
    logic              cnt_dec;
    logic              cap_rsp;
    logic              rsp_done;
    logic              rsp_drop;

    pm_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // abort outranks every other transition, including a same-cycle handshake.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        load_req  = 1'b0;
        cnt_dec   = 1'b0;
        cap_rsp   = 1'b0;
        rsp_done  = 1'b0;
        rsp_drop  = 1'b0;
        case (state)
            IDLE: begin
                if (!abort && any_grant) begin
                    req_ready = grant;
                    load_req  = 1'b1;
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    cap_rsp   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP: begin
                if (abort) begin
                    rsp_drop  = 1'b1;
                    state_nxt = IDLE;
                end else if (rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            rr_ptr    <= '0;
            dp_in     <= '0;
            rsp_id    <= '0;
            cnt       <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            ops_done  <= '0;
        end else begin
            if (load_req) begin
                dp_in  <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
                rsp_id <= grant_idx;
                rr_ptr <= (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
                cnt    <= LAT_W'(PIPE_LAT-1);
            end else if (cnt_dec) begin
                cnt <= cnt - 1'b1;
            end
            if (cap_rsp) begin
                rsp_data  <= dp_out;
                rsp_valid <= 1'b1;
            end else if (rsp_done || rsp_drop) begin
                rsp_valid <= 1'b0;
            end
            if (rsp_done) begin
                ops_done <= ops_done + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pattern_merge_sched.sv
// Self-checking bench for pattern_merge_sched: directed table, corner sequences, random vs model.
module tb_pattern_merge_sched;

    localparam int N  = 4;
    localparam int DW = 15;
    localparam int RW = 13;
    localparam int PL = 2;
    localparam int CW = 16;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data = '0;
    logic [DW-1:0]   dp_in;
    logic [RW-1:0]   dp_out;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [IW-1:0]   rsp_id;
    logic [RW-1:0]   rsp_data;
    logic            abort = 1'b0;
    logic            busy;
    logic [CW-1:0]   ops_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pattern_merge_sched #(
        .N_REQ(N), .DATA_W(DW), .RES_W(RW), .PIPE_LAT(PL), .CNT_W(CW)
    ) dut (
        .blif_clk_net   (clk),
        .blif_reset_net (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .dp_in          (dp_in),
        .dp_out         (dp_out),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_data       (rsp_data),
        .abort          (abort),
        .busy           (busy),
        .ops_done       (ops_done)
    );

    // Stand-in for the merged-pattern netlist; maps 15'h1A5A to 13'h0155.
    function automatic logic [RW-1:0] dp_f(input logic [DW-1:0] x);
        return (x[12:0] ^ 13'h1B0F) + {11'd0, x[14:13]};
    endfunction
    assign dp_out = dp_f(dp_in);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_data();
        req_data = {$urandom, $urandom};
    endtask

    // Grant in the current cycle, then expect the response PIPE_LAT+1 cycles later.
    task automatic run_op(input logic [N-1:0] rv, input logic [DW-1:0] opnd,
                          input int exp_id, input logic [RW-1:0] exp_res);
        logic [CW-1:0] ops0;
        int lat;
        rand_data();
        req_data[exp_id*DW +: DW] = opnd;
        req_valid = rv;
        rsp_ready = 1'b1;
        abort = 1'b0;
        ops0 = ops_done;
        #1;
        chk("grant", 32'(req_ready), 32'(1 << exp_id));
        cyc();
        req_valid = '0;
        rand_data();
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            chk("ready_low_eval", 32'(req_ready), 0);
            cyc();
            lat++;
        end
        chk("latency", lat, PL + 1);
        chk("rsp_id", 32'(rsp_id), 32'(exp_id));
        chk("rsp_data", 32'(rsp_data), 32'(exp_res));
        chk("dp_in", 32'(dp_in), 32'(opnd));
        cyc();
        chk("rsp_valid_drop", 32'(rsp_valid), 0);
        chk("busy_idle", 32'(busy), 0);
        chk("ops_inc", 32'(ops_done), 32'(ops0 + 1'b1));
    endtask

    typedef struct {
        logic [N-1:0]  rv;
        logic [DW-1:0] opnd;
        int            exp_id;
        logic [RW-1:0] exp_res;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [CW-1:0] ops_s;
        logic [RW-1:0] dat_s;
        int g_cyc[5];
        int g_id[5];
        int ng;
        int to;
        // model state
        int m_rr, m_id, m_age, m_ops, w;
        logic m_busy;
        logic [DW-1:0] m_data;
        logic [N-1:0] exp_rdy;

        // Expected ids follow the rotating pointer by hand: 0 -> 3 -> 1 -> 2 -> 1 -> 2 -> 0 -> 1 -> 0.
        tbl[0] = '{4'b0100, 15'h1A5A, 2, 13'h0155};
        tbl[1] = '{4'b0011, 15'h0123, 0, dp_f(15'h0123)};
        tbl[2] = '{4'b0011, 15'h7FFF, 1, dp_f(15'h7FFF)};
        tbl[3] = '{4'b0011, 15'h0000, 0, dp_f(15'h0000)};
        tbl[4] = '{4'b1111, 15'h4321, 1, dp_f(15'h4321)};
        tbl[5] = '{4'b1000, 15'h6A6A, 3, dp_f(15'h6A6A)};
        tbl[6] = '{4'b1001, 15'h2BCD, 0, dp_f(15'h2BCD)};
        tbl[7] = '{4'b1001, 15'h5555, 3, dp_f(15'h5555)};

        @(negedge clk);
        cyc();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_ops", 32'(ops_done), 0);
        chk("rst_dp_in", 32'(dp_in), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        rst_n = 1'b1;
        cyc();

        for (int k = 0; k < 8; k++)
            run_op(tbl[k].rv, tbl[k].opnd, tbl[k].exp_id, tbl[k].exp_res);
        chk("ops_after_table", 32'(ops_done), 8);

        // Backpressure: response held for 10 cycles while others request.
        rand_data();
        req_data[1*DW +: DW] = 15'h3C3C;
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant", 32'(req_ready), 32'(4'b0010));
        cyc();
        req_valid = 4'b1111;
        to = 0;
        while (!rsp_valid && to < 20) begin cyc(); to++; end
        chk("bp_reached_resp", 32'(rsp_valid), 1);
        ops_s = ops_done;
        for (int c = 0; c < 10; c++) begin
            rand_data();
            #1;
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_id", 32'(rsp_id), 1);
            chk("bp_data", 32'(rsp_data), 32'(dp_f(15'h3C3C)));
            chk("bp_ready_low", 32'(req_ready), 0);
            chk("bp_ops", 32'(ops_done), 32'(ops_s));
            cyc();
        end
        rsp_ready = 1'b1;
        cyc();
        req_valid = '0;
        chk("bp_ops_inc", 32'(ops_done), 32'(ops_s + 1'b1));
        chk("bp_idle", 32'(busy), 0);

        // Abort in EVAL, then the pointer has advanced past the aborted winner.
        ops_s = ops_done;
        req_valid = 4'b0100;
        #1;
        chk("ab_grant", 32'(req_ready), 32'(4'b0100));
        cyc();
        req_valid = '0;
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_no_rsp", 32'(rsp_valid), 0);
        chk("ab_ops", 32'(ops_done), 32'(ops_s));
        run_op(4'b1111, 15'h1111, 3, dp_f(15'h1111));

        // Abort in IDLE blocks the grant.
        req_valid = 4'b1111;
        abort = 1'b1;
        #1;
        chk("ab_idle_ready", 32'(req_ready), 0);
        cyc();
        chk("ab_idle_busy", 32'(busy), 0);
        abort = 1'b0;
        req_valid = '0;

        // Reset while a response is pending.
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        cyc();
        req_valid = '0;
        to = 0;
        while (!rsp_valid && to < 20) begin cyc(); to++; end
        chk("rr_pre_valid", 32'(rsp_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ops", 32'(ops_done), 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Fairness with everybody requesting: 0,1,2,3,0 spaced PIPE_LAT+2 apart.
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            #1;
            if (req_ready != '0) begin
                g_cyc[ng] = c;
                g_id[ng] = 99;
                for (int b = 0; b < N; b++) if (req_ready[b]) g_id[ng] = b;
                chk("rr_onehot", 32'($countones(req_ready)), 1);
                ng++;
                if (ng == 5) req_valid = '0;
            end
            cyc();
        end
        chk("rr_count", ng, 5);
        for (int k = 0; k < ng; k++) begin
            chk("rr_order", g_id[k], k % N);
            if (k > 0) chk("rr_spacing", g_cyc[k] - g_cyc[k-1], PL + 2);
        end
        to = 0;
        while (busy && to < 20) begin cyc(); to++; end
        chk("rr_drain", 32'(busy), 0);

        // Random traffic against a transaction-level model.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        m_rr = 0; m_id = 0; m_age = 0; m_ops = 0; m_busy = 1'b0; m_data = '0;
        for (int c = 0; c < 1500; c++) begin
            req_valid = N'($urandom);
            rand_data();
            rsp_ready = ($urandom_range(0, 3) != 0);
            abort = ($urandom_range(0, 19) == 0);
            #1;
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
            exp_rdy = '0;
            if (!m_busy && !abort && w >= 0) exp_rdy[w] = 1'b1;
            chk("m_req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("m_busy", 32'(busy), 32'(m_busy));
            chk("m_rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age > PL));
            chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
            chk("m_dp_in", 32'(dp_in), 32'(m_data));
            chk("m_ops", 32'(ops_done), 32'(m_ops % 65536));
            if (m_busy && m_age > PL) chk("m_rsp_data", 32'(rsp_data), 32'(dp_f(m_data)));
            if (!m_busy) begin
                if (!abort && w >= 0) begin
                    m_busy = 1'b1; m_age = 1; m_id = w;
                    m_data = req_data[w*DW +: DW];
                    m_rr = (w + 1) % N;
                end
            end else if (abort) begin
                m_busy = 1'b0;
            end else if (m_age > PL && rsp_ready) begin
                m_busy = 1'b0;
                m_ops++;
            end else begin
                m_age++;
            end
            cyc();
        end

        dat_s = rsp_data;
        if (dat_s === 'x) chk("rsp_data_known", 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
